// File: rtl/diagv2_mem_arbiter.sv
// diagv2_mem_arbiter
//   Shares one single-port unified memory between the instruction-fetch port
//   and the load/store port of diagv2_core. Each access is a request/ack
//   handshake towards the memory. Data accesses win arbitration. A streak
//   counter caps back-to-back data grants while a fetch waits, so the fetch
//   port always makes progress.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   if_req/if_addr        fetch request (level) and address
//   if_valid/if_rdata     one-cycle completion pulse and fetched instruction
//   d_req/d_we/d_type     data request (level), store enable, memory type
//   d_addr/d_wdata        data address and store data
//   d_valid/d_rdata       one-cycle completion pulse and load data
//   mem_req/mem_we        memory request (held until mem_ack), write enable
//   mem_type/mem_addr     memory access type and address
//   mem_wdata             memory write data
//   mem_ack/mem_rdata     one-cycle completion pulse and read data from memory
module diagv2_mem_arbiter #(
    parameter int                 XLEN            = 64,
    parameter int                 ILEN            = 32,
    parameter int                 MTYPE_W         = 3,
    parameter logic [MTYPE_W-1:0] IFETCH_TYPE     = 3'b010,
    parameter int                 MAX_DATA_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [XLEN-1:0]    if_addr,
    output logic               if_valid,
    output logic [ILEN-1:0]    if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [MTYPE_W-1:0] d_type,
    input  logic [XLEN-1:0]    d_addr,
    input  logic [XLEN-1:0]    d_wdata,
    output logic               d_valid,
    output logic [XLEN-1:0]    d_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MTYPE_W-1:0] mem_type,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic               mem_ack,
    input  logic [XLEN-1:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    typedef enum logic [1:0] {LAST_NONE, LAST_I, LAST_D} last_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

    state_t     state, state_nxt;
    last_t      last;
    logic [3:0] streak;
    logic       cancel;
    logic       grant_i, grant_d;
    logic       owner_req;
    logic       busy;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Arbitration and next state. A requester whose valid pulse is on the
    // output this cycle still shows its old request, so it is not eligible.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        busy      = (state == BUSY_I) || (state == BUSY_D);
        owner_req = (state == BUSY_I) ? if_req : d_req;
        case (state)
            IDLE: begin
                if ((d_req && (last != LAST_D)) &&
                    (!(if_req && (last != LAST_I)) || (streak < STREAK_LIMIT))) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req && (last != LAST_I)) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered memory side, completion pulses and bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= LAST_NONE;
            streak    <= 4'd0;
            cancel    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_type  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state    <= state_nxt;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            last     <= LAST_NONE;

            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_type  <= d_type;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                // Only data grants that make a fetch wait count towards the cap
                streak    <= if_req ? sat_inc(streak) : 4'd0;
            end else if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_type  <= IFETCH_TYPE;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                streak    <= 4'd0;
            end

            if (busy) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    cancel  <= 1'b0;
                    // A withdrawn access still finishes in memory but is not reported
                    if (state == BUSY_I) begin
                        last <= LAST_I;
                        if (!cancel && if_req) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata[ILEN-1:0];
                        end
                    end else begin
                        last <= LAST_D;
                        if (!cancel && d_req) begin
                            d_valid <= 1'b1;
                            d_rdata <= mem_rdata;
                        end
                    end
                end else if (!owner_req) begin
                    cancel <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_diagv2_mem_arbiter.sv
// tb_diagv2_mem_arbiter
//   Directed bench for diagv2_mem_arbiter. Expected grants and completions
//   are queued when a request is driven and consumed by a monitor when the
//   memory request rises or a valid pulse appears. A small memory responder
//   acknowledges after a programmable number of cycles.
module tb_diagv2_mem_arbiter;

    localparam int XLEN    = 64;
    localparam int ILEN    = 32;
    localparam int MTYPE_W = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               if_req;
    logic [XLEN-1:0]    if_addr;
    logic               if_valid;
    logic [ILEN-1:0]    if_rdata;
    logic               d_req;
    logic               d_we;
    logic [MTYPE_W-1:0] d_type;
    logic [XLEN-1:0]    d_addr;
    logic [XLEN-1:0]    d_wdata;
    logic               d_valid;
    logic [XLEN-1:0]    d_rdata;
    logic               mem_req;
    logic               mem_we;
    logic [MTYPE_W-1:0] mem_type;
    logic [XLEN-1:0]    mem_addr;
    logic [XLEN-1:0]    mem_wdata;
    logic               mem_ack;
    logic [XLEN-1:0]    mem_rdata;

    diagv2_mem_arbiter #(
        .XLEN(XLEN), .ILEN(ILEN), .MTYPE_W(MTYPE_W),
        .IFETCH_TYPE(3'b010), .MAX_DATA_STREAK(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        chk_wdata;
    } grant_t;

    typedef struct {
        logic [63:0] data;
        logic        chk_data;
        int          cyc;
    } val_t;

    grant_t gq[$];
    val_t   iq[$];
    val_t   dq[$];
    grant_t cur;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ack_delay = 0;
    bit spur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h100) return 64'h0000_0000_00A0_0513;
        return {~a[31:0], a[31:0] ^ 32'h1357_9BDF};
    endfunction

    function automatic logic [63:0] fetch_model(input logic [63:0] a);
        logic [63:0] w;
        w = mem_model(a);
        return {32'd0, w[31:0]};
    endfunction

    function automatic grant_t mk_grant(input bit is_d, input bit we, input logic [2:0] typ,
                                        input logic [63:0] addr, input logic [63:0] wdata);
        grant_t g;
        g.we        = is_d ? we : 1'b0;
        g.typ       = is_d ? typ : 3'b010;
        g.addr      = addr;
        g.wdata     = wdata;
        g.chk_wdata = is_d && we;
        return g;
    endfunction

    function automatic val_t mk_val(input bit is_d, input bit we, input logic [63:0] addr, input int c);
        val_t v;
        v.data     = is_d ? mem_model(addr) : fetch_model(addr);
        v.chk_data = !(is_d && we);
        v.cyc      = c;
        return v;
    endfunction

    // Memory responder: acknowledges ack_delay cycles after mem_req rises
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (spur) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
                spur      = 1'b0;
            end else if (mem_req && reset) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: consumes expected grants and completions
    initial begin
        logic   prev_req;
        grant_t g;
        val_t   v;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 1'b0;
            end else begin
                if (if_valid) begin
                    if (iq.size() == 0) check("if_valid_unexpected", 64'(if_valid), 64'd0);
                    else begin
                        v = iq.pop_front();
                        check("if_rdata", 64'(if_rdata), v.data);
                        if (v.cyc >= 0) check("if_valid_cycle", 64'(cyc), 64'(v.cyc));
                    end
                end
                if (d_valid) begin
                    if (dq.size() == 0) check("d_valid_unexpected", 64'(d_valid), 64'd0);
                    else begin
                        v = dq.pop_front();
                        if (v.chk_data) check("d_rdata", d_rdata, v.data);
                        if (v.cyc >= 0) check("d_valid_cycle", 64'(cyc), 64'(v.cyc));
                    end
                end
                if (mem_req && !prev_req) begin
                    if (gq.size() == 0) check("mem_req_unexpected", 64'(mem_req), 64'd0);
                    else begin
                        g   = gq.pop_front();
                        cur = g;
                        check("grant_we", 64'(mem_we), 64'(g.we));
                        check("grant_type", 64'(mem_type), 64'(g.typ));
                        check("grant_addr", mem_addr, g.addr);
                        if (g.chk_wdata) check("grant_wdata", mem_wdata, g.wdata);
                    end
                end else if (mem_req) begin
                    check("hold_addr", mem_addr, cur.addr);
                    check("hold_we_type", {60'd0, mem_we, mem_type}, {60'd0, cur.we, cur.typ});
                    if (cur.chk_wdata) check("hold_wdata", mem_wdata, cur.wdata);
                end
                prev_req = mem_req;
            end
        end
    end

    // Single access: request held through its valid cycle, then dropped
    task automatic do_access(input bit is_d, input bit we, input logic [2:0] typ,
                             input logic [63:0] addr, input logic [63:0] wdata, input int k);
        bit seen;
        seen      = 1'b0;
        ack_delay = k;
        gq.push_back(mk_grant(is_d, we, typ, addr, wdata));
        if (is_d) dq.push_back(mk_val(1'b1, we, addr, cyc + 2 + k));
        else      iq.push_back(mk_val(1'b0, 1'b0, addr, cyc + 2 + k));
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_type = typ; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (is_d ? d_valid : if_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(is_d ? "d_valid_seen" : "if_valid_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    // Both ports requesting; each keeps requesting until its quota is served.
    // With yield set, the fetch side lowers its request in data-valid cycles.
    task automatic run_core(input bit yield, input string order, input int k);
        int ri, rd, ii, dd, guard;
        ri = 0; rd = 0; ii = 0; dd = 0; guard = 0;
        ack_delay = k;
        for (int i = 0; i < order.len(); i++) begin
            if (order[i] == "D") begin
                gq.push_back(mk_grant(1'b1, 1'b0, 3'b011, 64'h4000 + 64'(8 * dd), 64'd0));
                dq.push_back(mk_val(1'b1, 1'b0, 64'h4000 + 64'(8 * dd), -1));
                dd++;
            end else begin
                gq.push_back(mk_grant(1'b0, 1'b0, 3'b010, 64'h300 + 64'(4 * ii), 64'd0));
                iq.push_back(mk_val(1'b0, 1'b0, 64'h300 + 64'(4 * ii), -1));
                ii++;
            end
        end
        ri = ii; rd = dd;
        if_addr = 64'h300; d_addr = 64'h4000; d_we = 1'b0; d_type = 3'b011; d_wdata = '0;
        if_req  = (ri > 0); d_req = (rd > 0);
        while ((ri > 0 || rd > 0) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
            if (d_valid) begin
                rd--;
                if (rd == 0) d_req = 1'b0;
                else d_addr = d_addr + 64'd8;
            end
            if (if_valid) begin
                ri--;
                if (ri == 0) if_req = 1'b0;
                else if_addr = if_addr + 64'd4;
            end
            if (yield && ri > 0) if_req = !d_valid;
        end
        check("core_quota_served", 64'(ri + rd), 64'd0);
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int t0;
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_type = '0; d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_type", 64'(mem_type), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Lone fetch, ack two cycles after mem_req
        do_access(1'b0, 1'b0, 3'b010, 64'h100, 64'd0, 2);
        repeat (3) @(posedge clk);
        #1;

        // Store with zero-cycle ack, then a load
        do_access(1'b1, 1'b1, 3'b011, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D, 0);
        do_access(1'b1, 1'b0, 3'b011, 64'h2008, 64'd0, 1);
        repeat (2) @(posedge clk);
        #1;

        // Contention, both held: each completion hands the slot to the other port
        run_core(1'b0, "DIDIDI", 1);
        // Contention where fetch is idle in data-valid cycles: streak cap kicks in
        run_core(1'b1, "DDDDIDDDDI", 1);

        // Flush: fetch withdrawn while outstanding, pending load goes next
        ack_delay = 3;
        gq.push_back(mk_grant(1'b0, 1'b0, 3'b010, 64'h500, 64'd0));
        gq.push_back(mk_grant(1'b1, 1'b0, 3'b011, 64'h6000, 64'd0));
        t0 = cyc;
        dq.push_back(mk_val(1'b1, 1'b0, 64'h6000, t0 + 10));
        if_req = 1'b1; if_addr = 64'h500;
        @(posedge clk); #1;
        check("flush_mem_req_up", 64'(mem_req), 64'd1);
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_type = 3'b011; d_addr = 64'h6000;
        @(posedge clk); #1;
        check("flush_mem_req_held", 64'(mem_req), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (d_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("flush_d_valid_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a data access is outstanding
        ack_delay = 50;
        gq.push_back(mk_grant(1'b1, 1'b0, 3'b011, 64'h7000, 64'd0));
        d_req = 1'b1; d_we = 1'b0; d_type = 3'b011; d_addr = 64'h7000;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_busy", 64'(mem_req), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        check("midrst_d_valid", 64'(d_valid), 64'd0);
        check("midrst_mem_addr", mem_addr, 64'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 1'b0, 3'b010, 64'h800, 64'd0, 1);

        // Zero-latency back-to-back alternating requests
        do_access(1'b0, 1'b0, 3'b010, 64'h900, 64'd0, 0);
        do_access(1'b1, 1'b0, 3'b010, 64'hA00, 64'd0, 0);
        do_access(1'b0, 1'b0, 3'b010, 64'h904, 64'd0, 0);

        // Spurious ack while idle: nothing happens, read data holds
        spur = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("spur_quiet", {61'd0, if_valid, d_valid, mem_req}, 64'd0);
        end
        check("spur_d_rdata_hold", d_rdata, mem_model(64'hA00));
        check("spur_if_rdata_hold", 64'(if_rdata), fetch_model(64'h904));

        check("grant_queue_drained", 64'(gq.size()), 64'd0);
        check("ival_queue_drained", 64'(iq.size()), 64'd0);
        check("dval_queue_drained", 64'(dq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
